// File: rtl/xe4_audio_pkg.sv
// Shared register map, control bit positions and divider defaults for the XE4 PSG.
package xe4_audio_pkg;

    typedef enum logic [2:0] {
        REG_PER_LO = 3'd0,
        REG_PER_HI = 3'd1,
        REG_DUR_LO = 3'd2,
        REG_DUR_HI = 3'd3,
        REG_VOL    = 3'd4,
        REG_CTRL   = 3'd5,
        REG_RSVD   = 3'd6,
        REG_BUSY   = 3'd7
    } psg_reg_e;

    localparam int CTRL_LEFT  = 0;
    localparam int CTRL_RIGHT = 1;
    localparam int CTRL_LOOP  = 2;

    localparam int DEF_CLK_DIV  = 25;
    localparam int DEF_DUR_DIV  = 20000;
    localparam int DEF_TONE_DIV = 16;

    localparam int PER_W  = 13;
    localparam int DUR_W  = 16;
    localparam int VOL_W  = 5;
    localparam int CTRL_W = 3;

    typedef struct packed {
        logic [PER_W-1:0]  period;
        logic [DUR_W-1:0]  duration;
        logic [VOL_W-1:0]  volume;
        logic [CTRL_W-1:0] ctrl;
    } chan_regs_t;

    function automatic int mix_width(input int num_ch);
        return VOL_W + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/xe4_psg_channel.sv
// One tone channel: CPU-visible registers, pending note, duration countdown,
// square-wave tone generator and output level.
module xe4_psg_channel
    import xe4_audio_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  psg_reg_e         reg_sel,
    input  logic [7:0]       wr_data,
    input  logic             dur_tick,
    input  logic             tone_tick,
    output logic [7:0]       rd_data,
    output logic [VOL_W-1:0] level,
    output logic             left_en,
    output logic             right_en,
    output logic             busy
);

    chan_regs_t       regs;
    logic             pending;
    logic [PER_W-1:0] act_per;
    logic [VOL_W-1:0] act_vol;
    logic [DUR_W-1:0] dur_cnt;
    logic [PER_W-1:0] tone_cnt;
    logic             square;
    logic             pend_set;
    logic             load;

    assign pend_set = wr_en && (reg_sel <= REG_VOL);
    assign load     = dur_tick && (dur_cnt == '0) && pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                REG_PER_LO: regs.period[7:0]    <= wr_data;
                REG_PER_HI: regs.period[12:8]   <= wr_data[4:0];
                REG_DUR_LO: regs.duration[7:0]  <= wr_data;
                REG_DUR_HI: regs.duration[15:8] <= wr_data;
                REG_VOL:    regs.volume         <= wr_data[4:0];
                REG_CTRL:   regs.ctrl           <= wr_data[2:0];
                default:    ;
            endcase
        end
    end

    // A register write in the load cycle re-arms pending, so the new values are not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            busy    <= 1'b0;
            act_per <= '0;
            act_vol <= '0;
            dur_cnt <= '0;
        end else begin
            if (dur_tick) begin
                if (dur_cnt != '0) begin
                    dur_cnt <= dur_cnt - DUR_W'(1);
                end else if (pending) begin
                    act_per <= regs.period;
                    act_vol <= regs.volume;
                    dur_cnt <= regs.duration;
                    busy    <= 1'b1;
                    pending <= 1'b0;
                end else if (regs.ctrl[CTRL_LOOP]) begin
                    dur_cnt <= regs.duration;
                end else begin
                    act_vol <= '0;
                    busy    <= 1'b0;
                end
            end
            if (pend_set) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt <= '0;
            square   <= 1'b0;
        end else if (load) begin
            tone_cnt <= regs.period;
        end else if (tone_tick) begin
            if (tone_cnt == '0) begin
                tone_cnt <= act_per;
                square   <= (act_per == '0) ? 1'b1 : ~square;
            end else begin
                tone_cnt <= tone_cnt - PER_W'(1);
            end
        end
    end

    // Period 0 is a DC level, so it must not wait for a tone tick to go high.
    assign level    = (square || (act_per == '0)) ? act_vol : '0;
    assign left_en  = regs.ctrl[CTRL_LEFT];
    assign right_en = regs.ctrl[CTRL_RIGHT];

    always_comb begin
        rd_data = 8'h00;
        case (reg_sel)
            REG_PER_LO: rd_data = regs.period[7:0];
            REG_PER_HI: rd_data = {3'b000, regs.period[12:8]};
            REG_DUR_LO: rd_data = regs.duration[7:0];
            REG_DUR_HI: rd_data = regs.duration[15:8];
            REG_VOL:    rd_data = {3'b000, regs.volume};
            REG_CTRL:   rd_data = {5'b00000, regs.ctrl};
            default:    rd_data = 8'h00;
        endcase
    end

endmodule

// File: rtl/xe4_audio_psg.sv
// XE4 programmable sound generator: CPU decode, NUM_CH tone channels,
// stereo mixer and triangle-compare PWM outputs.
module xe4_audio_psg
    import xe4_audio_pkg::*;
#(
    parameter int         NUM_CH    = 3,
    parameter logic [8:0] BASE_ADDR = 9'h022,
    parameter int         CLK_DIV   = DEF_CLK_DIV,
    parameter int         DUR_DIV   = DEF_DUR_DIV,
    parameter int         TONE_DIV  = DEF_TONE_DIV
)(
    input  logic        sysclk,
    input  logic        sysrst_n,
    input  logic [15:0] Address,
    input  logic [7:0]  InData,
    input  logic        we,
    output logic [7:0]  OutData,
    output logic        LeftChannel,
    output logic        RightChannel
);

    localparam int MW = mix_width(NUM_CH);
    localparam int CW = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
    localparam int DW = (DUR_DIV  > 1) ? $clog2(DUR_DIV)  : 1;
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [MW-1:0] TRI_TOP = '1;

    logic [CW-1:0] clk_cnt;
    logic [DW-1:0] dur_pre;
    logic [TW-1:0] tone_pre;
    logic          tick;
    logic          dur_tick;
    logic          tone_tick;

    assign tick      = (clk_cnt == CW'(CLK_DIV - 1));
    assign dur_tick  = tick && (dur_pre == DW'(DUR_DIV - 1));
    assign tone_tick = tick && (tone_pre == TW'(TONE_DIV - 1));

    // Duration and tone prescalers only advance on the 2 MHz tick, keeping their strobes aligned to it.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            clk_cnt  <= '0;
            dur_pre  <= '0;
            tone_pre <= '0;
        end else begin
            clk_cnt <= tick ? '0 : clk_cnt + CW'(1);
            if (tick) begin
                dur_pre  <= dur_tick  ? '0 : dur_pre + DW'(1);
                tone_pre <= tone_tick ? '0 : tone_pre + TW'(1);
            end
        end
    end

    logic             select;
    logic [3:0]       ch_idx;
    psg_reg_e         reg_sel;
    logic [NUM_CH-1:0] busy_vec;
    logic [NUM_CH-1:0] left_vec;
    logic [NUM_CH-1:0] right_vec;
    logic [VOL_W-1:0] level_vec [NUM_CH];
    logic [7:0]       rd_vec    [NUM_CH];

    assign select  = (Address[15:7] == BASE_ADDR);
    assign ch_idx  = Address[6:3];
    assign reg_sel = psg_reg_e'(Address[2:0]);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        xe4_psg_channel u_ch (
            .clk       (sysclk),
            .rst_n     (sysrst_n),
            .wr_en     (select && we && (ch_idx == 4'(i))),
            .reg_sel   (reg_sel),
            .wr_data   (InData),
            .dur_tick  (dur_tick),
            .tone_tick (tone_tick),
            .rd_data   (rd_vec[i]),
            .level     (level_vec[i]),
            .left_en   (left_vec[i]),
            .right_en  (right_vec[i]),
            .busy      (busy_vec[i])
        );
    end

    logic [7:0] rd_next;

    always_comb begin
        rd_next = 8'h00;
        if (reg_sel == REG_BUSY) begin
            rd_next = 8'(busy_vec);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_idx == 4'(i)) begin
                    rd_next = rd_vec[i];
                end
            end
        end
    end

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            OutData <= 8'h00;
        end else if (select && !we) begin
            OutData <= rd_next;
        end
    end

    logic [MW-1:0] mix_l;
    logic [MW-1:0] mix_r;

    always_comb begin
        mix_l = '0;
        mix_r = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (left_vec[i]) begin
                mix_l = mix_l + MW'(level_vec[i]);
            end
            if (right_vec[i]) begin
                mix_r = mix_r + MW'(level_vec[i]);
            end
        end
    end

    logic [MW-1:0] tri_cnt;
    logic          tri_down;
    logic [MW-1:0] duty_l;
    logic [MW-1:0] duty_r;

    // Duty only changes at the triangle peak, so each high pulse sees one stable compare value.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            tri_cnt      <= '0;
            tri_down     <= 1'b0;
            duty_l       <= '0;
            duty_r       <= '0;
            LeftChannel  <= 1'b0;
            RightChannel <= 1'b0;
        end else begin
            if (!tri_down) begin
                if (tri_cnt == TRI_TOP) begin
                    tri_down <= 1'b1;
                    tri_cnt  <= tri_cnt - MW'(1);
                end else begin
                    tri_cnt <= tri_cnt + MW'(1);
                end
            end else begin
                if (tri_cnt == '0) begin
                    tri_down <= 1'b0;
                    tri_cnt  <= tri_cnt + MW'(1);
                end else begin
                    tri_cnt <= tri_cnt - MW'(1);
                end
            end
            if (tri_cnt == TRI_TOP) begin
                duty_l <= mix_l;
                duty_r <= mix_r;
            end
            LeftChannel  <= (tri_cnt < duty_l);
            RightChannel <= (tri_cnt < duty_r);
        end
    end

endmodule

// File: doc/xe4_audio_psg.md
XE4_AUDIO_PSG -- requirements
Module: xe4_audio_psg

Interface
REQ-001 Parameter NUM_CH, default 3, number of tone channels (1..8).
REQ-002 Parameter BASE_ADDR, default 9'h022, value matched against Address[15:7].
REQ-003 Parameter CLK_DIV, default 25, sysclk cycles per 2 MHz tick.
REQ-004 Parameter DUR_DIV, default 20000, 2 MHz ticks per duration tick (100 Hz).
REQ-005 Parameter TONE_DIV, default 16, 2 MHz ticks per tone tick (125 kHz).
REQ-006 sysclk  in  1  system clock (50 MHz).
REQ-007 sysrst_n  in  1  asynchronous active-low reset.
REQ-008 Address  in  16  CPU address.
REQ-009 InData  in  8  CPU write data.
REQ-010 we  in  1  write strobe; one write per sysclk cycle while high and address matches.
REQ-011 OutData  out  8  registered read data.
REQ-012 LeftChannel  out  1  left PWM output.
REQ-013 RightChannel  out  1  right PWM output.

Function
REQ-014 Address decode SHALL be: select = Address[15:7]==BASE_ADDR; ch = Address[6:3]; reg = Address[2:0].
REQ-015 Per-channel registers SHALL be: 0 period LSB; 1 period MSB[4:0]; 2 duration LSB; 3 duration MSB; 4 volume[4:0]; 5 control: bit0 left enable, bit1 right enable, bit2 loop.
REQ-016 Reads SHALL return register contents one cycle after select with we low; reg 7 of any ch SHALL return the busy bitmap, bit n = channel n active; ch>=NUM_CH SHALL read 8'h00 and ignore writes.
REQ-017 Any write to regs 0-4 of a channel SHALL set its pending flag; a write to reg 5 SHALL NOT.
REQ-018 On each duration tick, per channel: if duration counter nonzero, decrement it; if zero and pending, load period, duration, volume into the active set, clear pending, and restart the tone counter from the new period; if zero, not pending, and loop=1, reload the duration from the registers; otherwise set active volume to 0 and clear busy.
REQ-019 A write that coincides with the load tick SHALL re-set pending (write wins over clear).
REQ-020 On each tone tick, per channel: tone counter zero -> reload from active period and toggle square state; else decrement.
REQ-021 Active period 0 SHALL hold the square state high (DC at volume level).
REQ-022 Channel level SHALL be the active volume when square state is high, else 0.
REQ-023 Left mix SHALL be the sum of levels of channels with left enable set; right likewise; mix width MW = 5+clog2(NUM_CH), no saturation.
REQ-024 The PWM SHALL use a shared up/down triangle counter of MW bits, stepping once per sysclk between 0 and 2^MW-1.
REQ-025 Duty SHALL be sampled into the left/right compare registers only when the counter is at its top.
REQ-026 Output SHALL be high while counter < duty; duty 0 SHALL give constant low.
REQ-027 LeftChannel and RightChannel SHALL be registered, with 1-cycle latency from the compare.
REQ-028 Prescalers SHALL free-run; duration and tone ticks SHALL be single-cycle strobes aligned to the 2 MHz tick.

Reset
REQ-029 Asserting sysrst_n low SHALL asynchronously clear all registers, pending/busy flags, counters, prescalers, square states and duties to 0.
REQ-030 Reset SHALL force OutData=8'h00, LeftChannel=0, RightChannel=0.
REQ-031 Reset mid-note SHALL silence all outputs immediately.
REQ-032 Deassertion SHALL be synchronised externally; the first tick occurs CLK_DIV cycles after release.

Structure
REQ-033 Register offsets, control bit positions and default divider constants SHALL live in shared package xe4_audio_pkg.
REQ-034 Per-channel logic (pending, duration, tone, level) SHALL be sub-module xe4_psg_channel, instantiated NUM_CH times by generate.
REQ-035 Decode, mixer and PWM SHALL reside in the top.

Verification
REQ-036 Scenario 1: write ch0 period=1, duration=2, volume=31, control=3 -> after next duration tick, square at 125 kHz/4 on both mixes, busy bit0=1, silent and busy=0 about 30 ms later.
REQ-037 Scenario 2: loop=1, duration=1 -> tone continues indefinitely; clearing loop -> silence after the current duration expires.
REQ-038 Scenario 3: NUM_CH=3, all channels volume 31, period 0, left only -> left duty 93/127, right constant low.
REQ-039 Scenario 4: read reg 7 with ch1 active only -> OutData=8'h02 one cycle later; read ch 9 -> 8'h00.
REQ-040 Scenario 5: write reg 0 on the same cycle as the load tick -> pending stays 1 and the note reloads at the next zero.
REQ-041 Scenario 6: assert sysrst_n mid-note -> outputs low the same cycle; after release, all registers read 0.
